fp_mul_half_pipe: RTL

- Pipelined float multiplier computing 0.5*a*b, the 0.5*x*y^2 step of the Newton inverse-square-root iteration.
- It is the producer feeding fp_sub_1d5_pipe. Its output bus uses the same valid/ready, 31-bit magnitude, delay-operand and error-chain conventions that the subtract stage consumes.
- Free-running, no backpressure. One result per cycle. Fixed latency.

---
 rtl/fp_mul_half_pipe.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fp_mul_half_pipe.sv
// Pipelined 0.5*a*b on sign-less IEEE-754 singles for the inverse-sqrt Newton step.
// Latency 3 cycles, one result per cycle; no backpressure (ready only marks valid output).
// FP_MUL_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the result is truncated.
module fp_mul_half_pipe #(
   parameter int LATENCY = 3,
   parameter int DELAY_W = 31
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid,
   input  logic [30:0]        a,
   input  logic [30:0]        b,
   input  logic [DELAY_W-1:0] delay_in,
   input  logic               error_in,
   output logic [30:0]        prod,
   output logic [DELAY_W-1:0] delay_out,
   output logic               ready,
   output logic               error_out
);

   if (LATENCY != 3) begin : g_bad_latency
      $error("fp_mul_half_pipe: LATENCY must be 3");
   end

   // Truncation never looks below the result LSB, so the low product bits are not kept.
`ifdef FP_MUL_ROUND_NEAREST_EN
   localparam int PLSB = 0;
`else
   localparam int PLSB = 23;
`endif

   typedef logic [47:PLSB] prod_t;

   typedef struct packed {
      logic [23:0]        ma;
      logic [23:0]        mb;
      logic [9:0]         se;
      logic               zero;
      logic               special;
      logic               err;
      logic [DELAY_W-1:0] dly;
   } s1_t;

   typedef struct packed {
      prod_t              p;
      logic [9:0]         se;
      logic               zero;
      logic               special;
      logic               err;
      logic [DELAY_W-1:0] dly;
   } s2_t;

   logic        s1_vld, s2_vld;
   s1_t         s1, s1_d;
   s2_t         s2, s2_d;
   logic [30:0] prod_d;
   logic        err_d;
   logic [22:0] frac;
   logic signed [9:0] e;

   // Stage 1 decode: the -128 folds the 0.5 factor into the exponent bias.
   always_comb begin
      s1_d.ma      = {1'b1, a[22:0]};
      s1_d.mb      = {1'b1, b[22:0]};
      s1_d.se      = 10'({2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd128);
      s1_d.zero    = (a[30:23] == 8'h00) || (b[30:23] == 8'h00);
      s1_d.special = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
      s1_d.err     = error_in;
      s1_d.dly     = delay_in;
   end

   always_comb begin
      s2_d.p       = prod_t'(({24'd0, s1.ma} * {24'd0, s1.mb}) >> PLSB);
      s2_d.se      = s1.se;
      s2_d.zero    = s1.zero;
      s2_d.special = s1.special;
      s2_d.err     = s1.err;
      s2_d.dly     = s1.dly;
   end

`ifdef FP_MUL_ROUND_NEAREST_EN
   logic guard, sticky;
`endif

   always_comb begin
      prod_d = '0;
      err_d  = s2.err;
      if (s2.p[47]) begin
         frac = s2.p[46:24];
         e    = $signed(s2.se) + 10'sd1;
      end else begin
         frac = s2.p[45:23];
         e    = $signed(s2.se);
      end
`ifdef FP_MUL_ROUND_NEAREST_EN
      guard  = s2.p[47] ? s2.p[23] : s2.p[22];
      sticky = s2.p[47] ? (|s2.p[22:0]) : (|s2.p[21:0]);
      if (guard && (sticky || frac[0])) begin
         // Mantissa carry-out renormalises to 1.0 at the next exponent.
         if (&frac) begin
            frac = '0;
            e    = e + 10'sd1;
         end else begin
            frac = frac + 23'd1;
         end
      end
`endif
      if (s2.special) begin
         prod_d = 31'h7F80_0000;
         err_d  = 1'b1;
      end else if (s2.zero) begin
         prod_d = '0;
      end else if (e >= 10'sd255) begin
         prod_d = 31'h7F80_0000;
         err_d  = 1'b1;
      end else if (e <= 10'sd0) begin
         prod_d = '0;
      end else begin
         prod_d = {e[7:0], frac};
      end
   end

   // Data registers load only behind a valid token so delay stays paired with its product.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld    <= 1'b0;
         s2_vld    <= 1'b0;
         s1        <= '0;
         s2        <= '0;
         ready     <= 1'b0;
         prod      <= '0;
         delay_out <= '0;
         error_out <= 1'b0;
      end else begin
         s1_vld <= valid;
         s2_vld <= s1_vld;
         ready  <= s2_vld;
         if (valid)  s1 <= s1_d;
         if (s1_vld) s2 <= s2_d;
         if (s2_vld) begin
            prod      <= prod_d;
            delay_out <= s2.dly;
            error_out <= err_d;
         end
      end
   end

endmodule
